// File: rtl/pulse_readout_sequencer_pkg.sv
// Shared definitions for the pulse readout path: FSM state encoding, frame sync byte and the
// default capture length. Also used by data_buffer and the host-side frame decoder.
package pulse_readout_sequencer_pkg;

    // Sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CAPTURE   = 3'd1,
        ST_SEND_SYNC = 3'd2,
        ST_FETCH     = 3'd3,
        ST_SEND_HI   = 3'd4,
        ST_SEND_LO   = 3'd5,
        ST_WAIT_LAST = 3'd6,
        ST_HOLDOFF   = 3'd7
    } state_t;

    // First byte of every frame.
    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    // Samples captured per pulse, trigger sample included.
    localparam int unsigned N_SAMPLES_DEF = 16;

endpackage

// File: rtl/pulse_readout_sequencer_trigger.sv
// pulse_trigger: armed flag plus threshold compare.
// Ports: clk, rst_n; enable (sequencer is in IDLE); sample_in/sample_valid (ADC stream);
//        threshold (trigger level); trigger_c (combinational trigger, same cycle as the sample).
module pulse_trigger #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] threshold,
    output logic              trigger_c
);

    logic armed;
    logic below_c;

    assign below_c   = (sample_in < threshold);
    assign trigger_c = enable && sample_valid && armed && !below_c;

    // A valid sample in IDLE re-evaluates armed: below threshold arms, anything else
    // (including the trigger sample itself) leaves it clear. Samples outside IDLE are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed <= 1'b0;
        end else if (enable && sample_valid) begin
            armed <= below_c;
        end
    end

endmodule

// File: rtl/pulse_readout_sequencer.sv
// pulse_readout_sequencer: captures N_SAMPLES ADC samples after a threshold crossing into the
// buffer RAM, then reads them back and streams one frame (sync byte, then hi/lo byte per
// sample) to the UART transmitter, counts completed frames and waits HOLDOFF cycles.
// Ports: clk, rst_n; sample_in/sample_valid/threshold (ADC side);
//        buf_wr_en/buf_wr_addr/buf_wr_data, buf_rd_addr/buf_rd_data (buffer RAM, 1-cycle read);
//        tx_data/tx_start/tx_ready (UART); busy (not IDLE); pulse_count (completed frames).
module pulse_readout_sequencer
    import pulse_readout_sequencer_pkg::*;
#(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned N_SAMPLES = N_SAMPLES_DEF,
    parameter int unsigned ADDR_W    = 4,
    parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF,
    parameter int unsigned HOLDOFF   = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] threshold,
    output logic              buf_wr_en,
    output logic [ADDR_W-1:0] buf_wr_addr,
    output logic [DATA_W-1:0] buf_wr_data,
    output logic [ADDR_W-1:0] buf_rd_addr,
    input  logic [DATA_W-1:0] buf_rd_data,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_ready,
    output logic              busy,
    output logic [15:0]       pulse_count
);

    localparam int unsigned IDX_W = ADDR_W + 1;
    localparam int unsigned HO_W  = $clog2(HOLDOFF + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SAMPLES - 1);
    localparam logic [HO_W-1:0]  HO_LAST  = HO_W'(HOLDOFF - 1);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [HO_W-1:0]   ho_cnt_q, ho_cnt_d;
    logic              fetch_ph_q, fetch_ph_d;
    logic [DATA_W-1:0] hold_q, hold_d;

    logic              wr_en_d;
    logic [ADDR_W-1:0] wr_addr_d;
    logic [DATA_W-1:0] wr_data_d;
    logic [ADDR_W-1:0] rd_addr_d;
    logic [7:0]        tx_data_d;
    logic              tx_start_d;
    logic              busy_d;
    logic [15:0]       pc_d;

    logic              trigger_c;
    logic              tx_ok_c;

    pulse_trigger #(
        .DATA_W (DATA_W)
    ) u_trigger (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (state_q == ST_IDLE),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .threshold    (threshold),
        .trigger_c    (trigger_c)
    );

    // A new byte may be decided only while no start is in flight and the UART reports idle;
    // since tx_start is registered this also keeps starts at least two cycles apart.
    assign tx_ok_c = tx_ready && !tx_start;

    // Next-state and registered-output decode.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        ho_cnt_d   = ho_cnt_q;
        fetch_ph_d = fetch_ph_q;
        hold_d     = hold_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = '0;
        wr_data_d  = '0;
        rd_addr_d  = buf_rd_addr;
        tx_start_d = 1'b0;
        tx_data_d  = '0;
        pc_d       = pulse_count;

        case (state_q)
            ST_IDLE: begin
                if (trigger_c) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = '0;
                    wr_data_d = sample_in;
                    idx_d     = IDX_W'(1);
                    state_d   = (N_SAMPLES == 1) ? ST_SEND_SYNC : ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (sample_valid) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = idx_q[ADDR_W-1:0];
                    wr_data_d = sample_in;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_SEND_SYNC;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_SEND_SYNC: begin
                if (tx_ok_c) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = SYNC_BYTE;
                    idx_d      = '0;
                    rd_addr_d  = '0;
                    fetch_ph_d = 1'b0;
                    state_d    = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // Phase 0 presents the address, phase 1 sees the RAM output.
                if (!fetch_ph_q) begin
                    fetch_ph_d = 1'b1;
                end else begin
                    hold_d  = buf_rd_data;
                    state_d = ST_SEND_HI;
                end
            end
            ST_SEND_HI: begin
                if (tx_ok_c) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = 8'(hold_q[DATA_W-1:8]);
                    state_d    = ST_SEND_LO;
                end
            end
            ST_SEND_LO: begin
                if (tx_ok_c) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = hold_q[7:0];
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_WAIT_LAST;
                    end else begin
                        idx_d      = idx_q + IDX_W'(1);
                        rd_addr_d  = ADDR_W'(idx_q + IDX_W'(1));
                        fetch_ph_d = 1'b0;
                        state_d    = ST_FETCH;
                    end
                end
            end
            ST_WAIT_LAST: begin
                if (tx_ok_c) begin
                    pc_d     = pulse_count + 16'd1;
                    ho_cnt_d = '0;
                    state_d  = ST_HOLDOFF;
                end
            end
            ST_HOLDOFF: begin
                if (ho_cnt_q == HO_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    ho_cnt_d = ho_cnt_q + HO_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            ho_cnt_q    <= '0;
            fetch_ph_q  <= 1'b0;
            hold_q      <= '0;
            buf_wr_en   <= 1'b0;
            buf_wr_addr <= '0;
            buf_wr_data <= '0;
            buf_rd_addr <= '0;
            tx_data     <= '0;
            tx_start    <= 1'b0;
            busy        <= 1'b0;
            pulse_count <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            ho_cnt_q    <= ho_cnt_d;
            fetch_ph_q  <= fetch_ph_d;
            hold_q      <= hold_d;
            buf_wr_en   <= wr_en_d;
            buf_wr_addr <= wr_addr_d;
            buf_wr_data <= wr_data_d;
            buf_rd_addr <= rd_addr_d;
            tx_data     <= tx_data_d;
            tx_start    <= tx_start_d;
            busy        <= busy_d;
            pulse_count <= pc_d;
        end
    end

endmodule
